// File: rtl/bcd_pkg.sv
// Shared constants for the BCD range counter: digit geometry and prescaler sizing.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    // Prescaler width holding 0..div-1; a divide-by-one still needs one bit.
    function automatic int unsigned presc_width(input int unsigned div);
        return (div <= 32'd1) ? 32'd1 : 32'($clog2(div));
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit up/down cell; chained through cin/cout_c to form a multi-digit counter.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               step,
    input  logic               up,
    input  logic               cin,
    output logic [DIGIT_W-1:0] next_c,
    output logic               cout_c
);

    // A digit only moves when the step reaches it through the carry/borrow chain.
    always_comb begin
        next_c = digit;
        cout_c = 1'b0;
        if (step && cin) begin
            if (up) begin
                if (digit >= DIGIT_MAX) begin
                    next_c = '0;
                    cout_c = 1'b1;
                end else begin
                    next_c = digit + DIGIT_W'(1);
                end
            end else begin
                if (digit == '0) begin
                    next_c = DIGIT_MAX;
                    cout_c = 1'b1;
                end else begin
                    next_c = digit - DIGIT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bcd_range_counter.sv
// Prescaled BCD up/down counter bounded to [lo_bound, hi_bound] with wrap or saturate,
// synchronous load and error reporting for illegal loads or bounds.
module bcd_range_counter
    import bcd_pkg::*;
#(
    parameter int unsigned         DIGITS    = 2,
    parameter int unsigned         TICK_DIV  = 25_000_000,
    parameter logic [4*DIGITS-1:0] RESET_VAL = (4*DIGITS)'(8'h05)
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                en,
    input  logic                up,
    input  logic                sat,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic [4*DIGITS-1:0] lo_bound,
    input  logic [4*DIGITS-1:0] hi_bound,
    output logic [4*DIGITS-1:0] Result,
    output logic                tick_o,
    output logic                wrap_o,
    output logic                err_o
);

    localparam int unsigned W  = DIGITS * DIGIT_W;
    localparam int unsigned PW = presc_width(TICK_DIV);
    localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("bcd_range_counter: DIGITS must be 1..8");
    end
    if (TICK_DIV < 1 || TICK_DIV > 32'd67108864) begin : g_bad_div
        $error("bcd_range_counter: TICK_DIV must be 1..2^26");
    end

    function automatic logic all_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[i*DIGIT_W +: DIGIT_W] > DIGIT_MAX) ok = 1'b0;
        end
        return ok;
    endfunction

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_c;
    logic          step_c;
    logic          load_ok_c;
    logic          bounds_ok_c;
    logic          in_range_c;
    logic [W-1:0]  stepped_c;
    logic [W-1:0]  count_d;
    logic          wrap_d;
    logic          err_d;
    logic [DIGITS:0] carry;
    logic          unused_carry;

    // Free-running prescaler; its terminal count is the clock enable for the counter.
    always_comb begin
        tick_c  = (presc_q == TERM);
        presc_d = tick_c ? '0 : presc_q + PW'(1);
    end

    // Load has priority, so a coincident tick never steps the digits.
    assign step_c = tick_c & en & ~load;

    assign carry[0]     = 1'b1;
    assign unused_carry = carry[DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .digit  (Result[g*DIGIT_W +: DIGIT_W]),
            .step   (step_c),
            .up     (up),
            .cin    (carry[g]),
            .next_c (stepped_c[g*DIGIT_W +: DIGIT_W]),
            .cout_c (carry[g+1])
        );
    end

    // With every digit legal, BCD ordering matches plain unsigned ordering.
    always_comb begin
        load_ok_c   = all_bcd(load_val);
        bounds_ok_c = all_bcd(lo_bound) && all_bcd(hi_bound) && (lo_bound <= hi_bound);
        in_range_c  = (Result >= lo_bound) && (Result <= hi_bound);
    end

    // Next count and event pulses: load, then bad bounds, out-of-range recovery, bound hit, plain step.
    always_comb begin
        count_d = Result;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            if (load_ok_c) begin
                count_d = load_val;
            end else begin
                err_d = 1'b1;
            end
        end else if (tick_c && en) begin
            if (!bounds_ok_c) begin
                err_d = 1'b1;
            end else if (!in_range_c) begin
                count_d = up ? lo_bound : hi_bound;
            end else if (up && (Result == hi_bound)) begin
                wrap_d = 1'b1;
                if (!sat) count_d = lo_bound;
            end else if (!up && (Result == lo_bound)) begin
                wrap_d = 1'b1;
                if (!sat) count_d = hi_bound;
            end else begin
                count_d = stepped_c;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            presc_q <= '0;
            Result  <= RESET_VAL;
            tick_o  <= 1'b0;
            wrap_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            Result  <= count_d;
            tick_o  <= tick_c;
            wrap_o  <= wrap_d;
            err_o   <= err_d;
        end
    end

endmodule
